seg_clock_scan: RTL

Parametrised successor to the fixed hh:mm:ss display driver. It takes NUM_FIELDS binary fields (0..99 each) and converts each to two BCD digits. It drives NUM_BANKS four-digit seven-segment banks by time-multiplexed scanning, with scanning built in rather than delegated to a separate scan IP. In set mode it blinks the selected digit or its whole field, and it restarts the blink phase whenever the selection changes or set mode is entered.

---
 rtl/seg_clock_scan.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seg_clock_scan.sv
// Multiplexed seven-segment driver for NUM_FIELDS two-digit binary fields.
// Each field is split into tens/units and encoded to segments. NUM_BANKS four-digit
// banks are scanned in parallel. Set mode blinks the selected digit or field, and
// the blink phase restarts whenever the selection changes or set mode is entered.
module seg_clock_scan #(
    parameter int CLK_HZ     = 50000000,
    parameter int SCAN_HZ    = 1000,
    parameter int BLINK_HZ   = 2,
    parameter int NUM_FIELDS = 3,
    parameter int NUM_BANKS  = 2,
    parameter int POS_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7*NUM_FIELDS-1:0]  values,
    input  logic [POS_W-1:0]         pos,
    input  logic                     set_mod,
    input  logic                     flash_field,
    input  logic [4*NUM_BANKS-1:0]   dp,
    output logic [4*NUM_BANKS-1:0]   wei,
    output logic [8*NUM_BANKS-1:0]   duan
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int HALF_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SCAN_CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HALF_CW  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int NUM_DIG  = 2 * NUM_FIELDS;

    logic [SCAN_CW-1:0]     scan_cnt_r;
    logic [1:0]             scan_idx_r;
    logic [HALF_CW-1:0]     blink_cnt_r;
    logic                   blink_on_r;
    logic [POS_W-1:0]       pos_q_r;
    logic                   set_q_r;
    logic                   restart_s;
    logic [4*NUM_BANKS-1:0] wei_s;
    logic [8*NUM_BANKS-1:0] duan_s;
    int                     d_s;
    int                     f_s;
    logic [6:0]             v_s;
    logic [6:0]             seg_s;
    logic [7:0]             byte_s;
    logic                   in_set_s;

    // Decimal digit to {g,f,e,d,c,b,a}; anything outside 0..9 is blank.
    function automatic logic [6:0] seg7(input logic [6:0] n);
        logic [6:0] s;
        case (n)
            7'd0:    s = 7'h3F;
            7'd1:    s = 7'h06;
            7'd2:    s = 7'h5B;
            7'd3:    s = 7'h4F;
            7'd4:    s = 7'h66;
            7'd5:    s = 7'h6D;
            7'd6:    s = 7'h7D;
            7'd7:    s = 7'h07;
            7'd8:    s = 7'h7F;
            7'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Entering set mode or moving the selection restarts the blink with the digit visible.
    assign restart_s = set_mod && (!set_q_r || (pos != pos_q_r));

    // Digit scan timer: dwell SCAN_DIV cycles per digit, step through the 4 bank positions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_r <= '0;
            scan_idx_r <= 2'd0;
        end else if (scan_cnt_r == SCAN_CW'(SCAN_DIV - 1)) begin
            scan_cnt_r <= '0;
            scan_idx_r <= scan_idx_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_CW'(1);
        end
    end

    // Blink phase timer plus the sampled selection used to detect restarts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
            pos_q_r     <= '0;
            set_q_r     <= 1'b0;
        end else begin
            pos_q_r <= pos;
            set_q_r <= set_mod;
            if (!set_mod || restart_s) begin
                blink_cnt_r <= '0;
                blink_on_r  <= 1'b1;
            end else if (blink_cnt_r == HALF_CW'(HALF_DIV - 1)) begin
                blink_cnt_r <= '0;
                blink_on_r  <= ~blink_on_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + HALF_CW'(1);
            end
        end
    end

    // Next digit enables and segment bytes for every bank at the current scan position.
    always_comb begin
        wei_s    = '0;
        duan_s   = '0;
        d_s      = 0;
        f_s      = 0;
        v_s      = 7'd0;
        seg_s    = 7'h00;
        byte_s   = 8'h00;
        in_set_s = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            d_s        = 4 * b + int'(scan_idx_r);
            f_s        = d_s >> 1;
            wei_s[d_s] = 1'b1;
            if (d_s < NUM_DIG) begin
                v_s = values[7*f_s +: 7];
                if (v_s > 7'd99) begin
                    seg_s = 7'h40;
                end else if ((d_s % 2) == 1) begin
                    seg_s = seg7(v_s / 7'd10);
                end else begin
                    seg_s = seg7(v_s % 7'd10);
                end
                byte_s = {dp[d_s], seg_s};
            end else begin
                seg_s  = 7'h00;
                byte_s = 8'h00;
            end
            if (set_mod && (int'(pos) < NUM_DIG)) begin
                if (flash_field) begin
                    in_set_s = ((d_s >> 1) == (int'(pos) >> 1));
                end else begin
                    in_set_s = (d_s == int'(pos));
                end
            end else begin
                in_set_s = 1'b0;
            end
            if (in_set_s && !blink_on_r) begin
                duan_s[8*b +: 8] = 8'h00;
            end else begin
                duan_s[8*b +: 8] = byte_s;
            end
        end
    end

    // Output registers: one cycle behind the scan position and inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wei  <= '0;
            duan <= '0;
        end else begin
            wei  <= wei_s;
            duan <= duan_s;
        end
    end

endmodule
